// File: rtl/bytecode_prefetch_unit.sv
// Byte-granular instruction prefetch buffer feeding a variable-length bytecode decoder.
module bytecode_prefetch_unit #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned OUT_BYTES     = 4,
  parameter int unsigned PC_RESET      = 0,
  localparam int unsigned CW           = $clog2(OUT_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_addr,
  output logic                     mem_start,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic                     mem_ready,
  input  logic [31:0]              mem_rdata,
  output logic [8*OUT_BYTES-1:0]   out_bytes,
  output logic [CW-1:0]            out_count,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  input  logic                     consume,
  input  logic [CW-1:0]            consume_count,
  output logic                     consume_err
);

  localparam int unsigned AW        = ADDRESS_WIDTH;
  localparam int unsigned BUF_BYTES = 4 * DEPTH;
  localparam int unsigned BW        = 8 * BUF_BYTES;
  localparam int unsigned OW        = 8 * OUT_BYTES;
  localparam int unsigned OCW       = $clog2(BUF_BYTES + 1);

  // Highest occupancy that still leaves room for a whole word.
  localparam logic [OCW-1:0] FREE_LIM = OCW'(BUF_BYTES - 4);
  localparam logic [AW-1:0]  PC_RST   = AW'(PC_RESET);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;          // oldest byte in the top lane, unused lanes zero
  logic [OCW-1:0]  occ_q, occ_d;
  logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
  logic [1:0]      skip_q, skip_d;
  logic [AW-1:0]   out_pc_q, out_pc_d;
  logic [OW-1:0]   out_bytes_q, out_bytes_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic            mem_start_q, mem_start_d;
  logic [AW-1:0]   mem_address_q, mem_address_d;
  logic            consume_err_q, consume_err_d;

  logic            legal;
  logic [OCW-1:0]  cons;
  logic [OCW-1:0]  occ_mid;
  logic [OCW-1:0]  n_app;
  logic [31:0]     app_word;

  // Next-state: redirect flush, consume shift, memory append, FSM and registered outputs.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    occ_d         = occ_q;
    fetch_addr_d  = fetch_addr_q;
    skip_d        = skip_q;
    out_pc_d      = out_pc_q;
    consume_err_d = 1'b0;
    cons          = '0;
    occ_mid       = occ_q;
    legal         = consume && (consume_count != '0) && (consume_count <= out_count_q);
    n_app         = OCW'(4) - OCW'(skip_q);
    app_word      = mem_rdata << {skip_q, 3'b000};

    if (redirect) begin
      buf_d        = '0;
      occ_d        = '0;
      out_pc_d     = redirect_addr;
      fetch_addr_d = {redirect_addr[AW-1:2], 2'b00};
      skip_d       = redirect_addr[1:0];
      // An issued request can't be withdrawn; drain it unless it completes now.
      unique case (state_q)
        S_FETCH: state_d = mem_ready ? S_IDLE : S_DRAIN;
        S_DRAIN: state_d = mem_ready ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      if (legal) cons = OCW'(consume_count);
      consume_err_d = consume && !legal;
      occ_mid       = occ_q - cons;
      buf_d         = buf_q << {cons, 3'b000};
      occ_d         = occ_mid;
      out_pc_d      = out_pc_q + AW'(cons);
      unique case (state_q)
        S_IDLE: begin
          if (run && (occ_q <= FREE_LIM)) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            buf_d        = buf_d | ({app_word, {(BW-32){1'b0}}} >> {occ_mid, 3'b000});
            occ_d        = occ_mid + n_app;
            fetch_addr_d = fetch_addr_q + AW'(4);
            skip_d       = 2'b00;
            // Room check uses pre-consume occupancy so an append can never overflow.
            state_d      = (run && ((occ_q + n_app) <= FREE_LIM)) ? S_FETCH : S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mem_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    out_bytes_d   = buf_d[BW-1 -: OW];
    out_count_d   = (occ_d >= OCW'(OUT_BYTES)) ? CW'(OUT_BYTES) : CW'(occ_d);
    mem_start_d   = (state_d != S_IDLE);
    // A draining request keeps the address it was issued with.
    mem_address_d = (state_d == S_DRAIN) ? mem_address_q : fetch_addr_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      occ_q         <= '0;
      fetch_addr_q  <= {PC_RST[AW-1:2], 2'b00};
      skip_q        <= PC_RST[1:0];
      out_pc_q      <= PC_RST;
      out_bytes_q   <= '0;
      out_count_q   <= '0;
      mem_start_q   <= 1'b0;
      mem_address_q <= {PC_RST[AW-1:2], 2'b00};
      consume_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      occ_q         <= occ_d;
      fetch_addr_q  <= fetch_addr_d;
      skip_q        <= skip_d;
      out_pc_q      <= out_pc_d;
      out_bytes_q   <= out_bytes_d;
      out_count_q   <= out_count_d;
      mem_start_q   <= mem_start_d;
      mem_address_q <= mem_address_d;
      consume_err_q <= consume_err_d;
    end
  end

  assign mem_start   = mem_start_q;
  assign mem_address = mem_address_q;
  assign out_bytes   = out_bytes_q;
  assign out_count   = out_count_q;
  assign out_pc      = out_pc_q;
  assign consume_err = consume_err_q;

endmodule
